// File: rtl/ram_boot_ctrl.sv
// ram_boot_ctrl: clears a shared RAM, loads it from a byte loader, then hands it to the CPU
module ram_boot_ctrl #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          cpu_rst,
  output logic [1:0]    state,
  output logic [AW:0]   ld_count
);
  typedef enum logic [1:0] {CLEAR = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
  state_t st, st_n;
  logic [AW-1:0] cnt, cnt_n;
  logic [AW:0] ldc_n;
  logic is_ld, is_rn, is_cl, acc, last;
  assign is_ld = st == LOAD;
  assign is_rn = st == RUN;
  assign is_cl = !is_ld && !is_rn;
  assign acc = is_ld && ld_valid;
  assign last = &cnt;
  assign state = st;
  assign ld_ready = is_ld;
  assign cpu_rst = !is_rn;
  assign mem_we = is_cl || acc || (is_rn && cpu_we);
  assign mem_addr = is_rn ? cpu_addr : cnt;
  assign mem_wdata = is_rn ? cpu_wdata : acc ? ld_data : '0;
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    ldc_n = ld_count;
    if (is_cl) begin
      cnt_n = cnt + 1'b1;
      st_n = last ? LOAD : CLEAR;
    end else if (acc) begin
      cnt_n = cnt + 1'b1;
      ldc_n = ld_count + 1'b1;
      st_n = (ld_last || last) ? RUN : LOAD;
    end else if (is_rn && reload) begin
      st_n = CLEAR;
      cnt_n = '0;
      ldc_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= CLEAR;
      cnt <= '0;
      ld_count <= '0;
    end else begin
      st <= st_n;
      cnt <= cnt_n;
      ld_count <= ldc_n;
    end
  end
endmodule
